// File: rtl/tanh_segment_fetch.sv
// Tanh front end: splits |x| into a table segment and in-segment fraction,
// then fetches the two bracketing samples for the downstream interpolator.
module tanh_segment_fetch #(
    parameter int DATA_W    = 8,
    parameter int FRAC_W    = 4,
    parameter int N_ENTRIES = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] base,
    output logic [DATA_W-1:0] next_data,
    output logic [DATA_W-1:0] change,
    output logic [DATA_W-1:0] remaining,
    input  logic              tbl_we,
    input  logic [3:0]        tbl_addr,
    input  logic [DATA_W-1:0] tbl_data
);

    localparam int MAG_W = DATA_W + 1;
    localparam int IDX_W = MAG_W - FRAC_W;
    localparam int TA_W  = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);
    localparam logic [TA_W-1:0]  LAST_TA  = TA_W'(N_ENTRIES - 1);

    typedef struct packed {
        logic              neg;
        logic [TA_W-1:0]   idx_b;
        logic [TA_W-1:0]   idx_n;
        logic [FRAC_W-1:0] frac;
    } s1_t;

    function automatic logic [DATA_W-1:0] def_entry(input int i);
        case (i)
            0:       return '0;
            1:       return DATA_W'(12);
            2:       return DATA_W'(15);
            default: return DATA_W'(16);
        endcase
    endfunction

    logic [DATA_W-1:0] tbl_q [N_ENTRIES];

    s1_t               s1_q, s1_d;
    logic              s1_valid_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] next_q, next_d;
    logic [DATA_W-1:0] change_q, change_d;
    logic [DATA_W-1:0] rem_q, rem_d;

    logic              s2_adv;
    logic              s1_adv;
    logic [MAG_W-1:0]  sx;
    logic [MAG_W-1:0]  mag;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] b_rd;
    logic [DATA_W-1:0] n_rd;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv && !rst;

    // One extra magnitude bit so the most negative input keeps its size.
    always_comb begin
        sx       = {x[DATA_W-1], x};
        mag      = x[DATA_W-1] ? (~sx + MAG_W'(1)) : sx;
        idx      = mag[MAG_W-1:FRAC_W];
        s1_d     = '0;
        s1_d.neg = x[DATA_W-1];
        if (idx >= LAST_IDX) begin
            s1_d.idx_b = LAST_TA;
            s1_d.idx_n = LAST_TA;
            s1_d.frac  = '0;
        end else begin
            s1_d.idx_b = idx[TA_W-1:0];
            s1_d.idx_n = idx[TA_W-1:0] + TA_W'(1);
            s1_d.frac  = mag[FRAC_W-1:0];
        end
    end

    always_comb begin
        b_rd     = tbl_q[s1_q.idx_b];
        n_rd     = tbl_q[s1_q.idx_n];
        base_d   = s1_q.neg ? -b_rd : b_rd;
        next_d   = s1_q.neg ? -n_rd : n_rd;
        change_d = next_d - base_d;
        rem_d    = {{(DATA_W-FRAC_W){1'b0}}, s1_q.frac};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            base_q      <= '0;
            next_q      <= '0;
            change_q    <= '0;
            rem_q       <= '0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                base_q   <= base_d;
                next_q   <= next_d;
                change_q <= change_d;
                rem_q    <= rem_d;
            end
        end
    end

    // Stage 2 samples tbl_q before this edge's write lands: read-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                tbl_q[i] <= def_entry(i);
            end
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (tbl_we && tbl_addr == TA_W'(i)) begin
                    tbl_q[i] <= tbl_data;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign base      = base_q;
    assign next_data = next_q;
    assign change    = change_q;
    assign remaining = rem_q;

endmodule
